gpi_input_conditioner: RTL and testbench

//  Upstream conditioning stage for the APB GPI peripheral: takes raw asynchronous pad inputs
//  (buttons/switches), synchronises them into PCLK, debounces each bit on a shared sample tick,
//  and drives the clean vector into the GPI peripheral's gpi input. Also emits one-cycle

---
 rtl/gpi_cond_pkg.sv | 18 +
 rtl/gpi_debounce_bit.sv | 60 ++++++
 rtl/gpi_input_conditioner.sv | 54 +++++
 tb/tb_gpi_input_conditioner.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/gpi_cond_pkg.sv
// Shared defaults and counter-width helpers for the GPI input conditioner and the GPI peripheral top.
package gpi_cond_pkg;

  localparam int WIDTH_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TICK_DIV_DEF    = 100000;
  localparam int DB_COUNT_DEF    = 4;

  // Prescaler counts 0..tick_div-1; keep at least one bit so TICK_DIV=1 still elaborates.
  function automatic int prescale_width(input int tick_div);
    return (tick_div <= 1) ? 1 : $clog2(tick_div);
  endfunction

  function automatic int db_cnt_width(input int db_count);
    return $clog2(db_count + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One input bit: synchroniser chain, tick-sampled debounce counter, stable level and edge pulses.
module gpi_debounce_bit
  import gpi_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_COUNT    = DB_COUNT_DEF
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic pin,
  input  logic enable,
  input  logic tick,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = db_cnt_width(DB_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CW-1:0]          db_cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      db_cnt <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      // Disable beats any update on the same tick and drops the level silently.
      if (!enable) begin
        db_cnt <= '0;
        stable <= 1'b0;
      end else if (tick) begin
        if (sync_lvl == stable) begin
          db_cnt <= '0;
        end else if (db_cnt == CW'(DB_COUNT - 1)) begin
          db_cnt <= '0;
          stable <= sync_lvl;
          rise   <= sync_lvl;
          fall   <= ~sync_lvl;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gpi_input_conditioner.sv
// Pad-input conditioner: shared sample-tick prescaler plus WIDTH independent debounced bits.
module gpi_input_conditioner
  import gpi_cond_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int DB_COUNT    = DB_COUNT_DEF
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] enable,
  output logic [WIDTH-1:0] gpi_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             tick
);

  localparam int PW = prescale_width(TICK_DIV);

  logic [PW-1:0] pre_cnt;
  logic          pre_wrap;

  assign pre_wrap = (pre_cnt == PW'(TICK_DIV - 1));

  // tick is the registered wrap, so it lands TICK_DIV cycles after reset release.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + PW'(1);
      tick    <= pre_wrap;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpi_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_COUNT    (DB_COUNT)
    ) u_bit (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .pin    (pin_in[i]),
      .enable (enable[i]),
      .tick   (tick),
      .stable (gpi_out[i]),
      .rise   (rise_pulse[i]),
      .fall   (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Directed bench for gpi_input_conditioner with WIDTH=8, SYNC_STAGES=2, TICK_DIV=4, DB_COUNT=3.
module tb_gpi_input_conditioner;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] pin_in;
  logic [7:0] enable;
  logic [7:0] gpi_out;
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  gpi_input_conditioner #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .TICK_DIV    (4),
    .DB_COUNT    (3)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .pin_in     (pin_in),
    .enable     (enable),
    .gpi_out    (gpi_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .tick       (tick)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge number k counted from reset release.
  task automatic step_to(input int k);
    while (cyc < k) begin
      @(posedge PCLK);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input logic [7:0] p, input logic [7:0] e, input string tag);
    PRESET = 1'b1;
    pin_in = p;
    enable = e;
    #1;
    chk({tag, "_gpi_async"},  gpi_out,      8'h00);
    chk({tag, "_rise_async"}, rise_pulse,   8'h00);
    chk({tag, "_fall_async"}, fall_pulse,   8'h00);
    chk({tag, "_tick_async"}, {7'b0, tick}, 8'h00);
    repeat (2) @(posedge PCLK);
    #1;
    chk({tag, "_gpi_held"},  gpi_out,      8'h00);
    chk({tag, "_tick_held"}, {7'b0, tick}, 8'h00);
    PRESET = 1'b0;
    cyc    = 0;
  endtask

  initial begin
    PRESET = 1'b1;
    pin_in = 8'h00;
    enable = 8'h00;

    // All pins high from reset: ticks after edges 4, 8, 12; accept at edge 13.
    do_reset(8'hFF, 8'hFF, "t1");
    step_to(3);  chk("t1_tick_e3",  {7'b0, tick}, 8'h00);
    step_to(4);  chk("t1_tick_e4",  {7'b0, tick}, 8'h01);
    step_to(5);  chk("t1_tick_e5",  {7'b0, tick}, 8'h00);
    step_to(8);  chk("t1_tick_e8",  {7'b0, tick}, 8'h01);
    step_to(12); chk("t1_gpi_e12",  gpi_out,      8'h00);
    step_to(13); chk("t1_gpi_e13",  gpi_out,      8'hFF);
                 chk("t1_rise_e13", rise_pulse,   8'hFF);
                 chk("t1_fall_e13", fall_pulse,   8'h00);
    step_to(14); chk("t1_rise_e14", rise_pulse,   8'h00);
                 chk("t1_gpi_e14",  gpi_out,      8'hFF);

    // Bit 2 disabled (silent drop), bit 3 pad goes low; both resolve on edge 25.
    enable = 8'hFB;
    pin_in = 8'hF7;
    step_to(15); chk("t5_gpi_dis",   gpi_out,    8'hFB);
                 chk("t5_fall_dis",  fall_pulse, 8'h00);
    step_to(16); chk("t5_fall_e16",  fall_pulse, 8'h00);
    enable = 8'hFF;
    step_to(24); chk("t45_gpi_e24",  gpi_out,    8'hFB);
                 chk("t45_fall_e24", fall_pulse, 8'h00);
    step_to(25); chk("t45_gpi_e25",  gpi_out,    8'hF7);
                 chk("t45_rise_e25", rise_pulse, 8'h04);
                 chk("t45_fall_e25", fall_pulse, 8'h08);
    step_to(26); chk("t45_rise_e26", rise_pulse, 8'h00);
                 chk("t45_fall_e26", fall_pulse, 8'h00);
                 chk("t45_gpi_e26",  gpi_out,    8'hF7);

    // Bit 0 rises with only bit 0 enabled; disabled high pins must not move.
    do_reset(8'h0E, 8'h01, "t2");
    step_to(6);  pin_in = 8'h0F;
    step_to(16); chk("t2_gpi_e16",  gpi_out,    8'h00);
    step_to(17); chk("t2_gpi_e17",  gpi_out,    8'h01);
                 chk("t2_rise_e17", rise_pulse, 8'h01);
                 chk("t2_fall_e17", fall_pulse, 8'h00);
    step_to(18); chk("t2_rise_e18", rise_pulse, 8'h00);
                 chk("t2_gpi_e18",  gpi_out,    8'h01);

    // Bit 1 glitch: high for two ticks, low for one, then high again needs three fresh ticks.
    enable = 8'h03;
    pin_in = 8'h03;
    step_to(26); pin_in = 8'h01;
    step_to(29); chk("t3_gpi_e29",  gpi_out,    8'h01);
                 chk("t3_rise_e29", rise_pulse, 8'h00);
    step_to(30); pin_in = 8'h03;
    step_to(33); chk("t3_gpi_e33",  gpi_out,    8'h01);
    step_to(37); chk("t3_gpi_e37",  gpi_out,    8'h01);
                 chk("t3_rise_e37", rise_pulse, 8'h00);
    step_to(41); chk("t3_gpi_e41",  gpi_out,    8'h03);
                 chk("t3_rise_e41", rise_pulse, 8'h02);

    // Bit 0 falling with db_cnt at 2 and tick high when reset hits.
    pin_in = 8'h02;
    step_to(52); chk("t6_tick_pre", {7'b0, tick}, 8'h01);
                 chk("t6_gpi_pre",  gpi_out,      8'h03);
    do_reset(8'h02, 8'h03, "t6");
    step_to(3);  chk("t6_tick_e3",  {7'b0, tick}, 8'h00);
    step_to(4);  chk("t6_tick_e4",  {7'b0, tick}, 8'h01);
    step_to(5);  chk("t6_gpi_e5",   gpi_out,      8'h00);
                 chk("t6_rise_e5",  rise_pulse,   8'h00);
    step_to(12); chk("t6_gpi_e12",  gpi_out,      8'h00);
    step_to(13); chk("t6_gpi_e13",  gpi_out,      8'h02);
                 chk("t6_rise_e13", rise_pulse,   8'h02);
                 chk("t6_fall_e13", fall_pulse,   8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
